// File: rtl/decode_queue_pkg.sv
// Shared types for the decode stage: the decoded-instruction record and the
// default decode-queue depth.
package decode_queue_pkg;

    localparam int DQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } decode_data;

endpackage

// File: rtl/decode_queue.sv
// Decoded-instruction FIFO between the frontend and rename, flushed on mispredict.
// Optional feature macro: DECODE_QUEUE_BYPASS_EN (empty-queue fall-through to rename).
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = DQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  decode_data               data_in,
    output logic                     ready_in,
    output logic                     valid_out,
    output decode_data               data_out,
    input  logic                     ready_out,
    input  logic                     mispredict,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    decode_data        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              has_data;
    logic              push;
    logic              pop;
    logic              bypass_take;

    assign has_data = (count != '0);
    // Space is judged on occupancy alone, so a full queue never reuses a slot being popped.
    assign ready_in = (count < FULL_COUNT) && !reset;

`ifdef DECODE_QUEUE_BYPASS_EN
    logic bypass;

    assign bypass      = !has_data && valid_in && !mispredict && !reset;
    assign valid_out   = (has_data && !mispredict) || bypass;
    assign data_out    = has_data ? mem[rd_ptr] : (bypass ? data_in : '0);
    // A bypassed instruction taken by rename the same cycle is never stored.
    assign bypass_take = bypass && ready_out;
`else
    assign valid_out   = has_data && !mispredict;
    assign data_out    = has_data ? mem[rd_ptr] : '0;
    assign bypass_take = 1'b0;
`endif

    assign push = valid_in && ready_in && !mispredict && !bypass_take;
    assign pop  = has_data && ready_out && !mispredict;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: data_out is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (default depth 8).
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic        clk;
    logic        reset;
    logic        valid_in;
    decode_data  data_in;
    logic        ready_in;
    logic        valid_out;
    decode_data  data_out;
    logic        ready_out;
    logic        mispredict;
    logic [3:0]  count;

    int assertCount = 0;
    int failCount   = 0;

    decode_queue #(.DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .ready_out  (ready_out),
        .mispredict (mispredict),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic decode_data mk(input logic [31:0] pc);
        decode_data d;
        d.pc    = pc;
        d.instr = pc ^ 32'h1357_9BDF;
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic r, input logic m);
        valid_in   = v;
        data_in    = mk(pc);
        ready_out  = r;
        mispredict = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_valid_out", 64'(valid_out), 64'd0);
        checkOutput("reset_ready_in", 64'(ready_in), 64'd0);
        checkOutput("reset_data_out", 64'(data_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Three pushes with rename stalled, then drain in order
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        #1;
`ifdef DECODE_QUEUE_BYPASS_EN
        checkOutput("bypass_valid_first", 64'(valid_out), 64'd1);
`else
        checkOutput("no_comb_path_valid", 64'(valid_out), 64'd0);
`endif
        tick();
        checkOutput("latency_valid_out", 64'(valid_out), 64'd1);
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t1_count3", 64'(count), 64'd3);
        checkOutput("t1_ready_in", 64'(ready_in), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("t1_pop_data", 64'(data_out), 64'(mk(32'(4 * i))));
            tick();
        end
        checkOutput("t1_count0", 64'(count), 64'd0);
        checkOutput("t1_valid0", 64'(valid_out), 64'd0);

        // Fill to 8, ninth offer ignored, one pop reopens space
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("t2_count8", 64'(count), 64'd8);
        checkOutput("t2_ready_full", 64'(ready_in), 64'd0);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        checkOutput("t2_ninth_ignored", 64'(count), 64'd8);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        checkOutput("t2_ready_indep", 64'(ready_in), 64'd0);
        checkOutput("t2_head", 64'(data_out), 64'(mk(32'h100)));
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t2_ready_after_pop", 64'(ready_in), 64'd1);
        checkOutput("t2_count7", 64'(count), 64'd7);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            #1;
            checkOutput("t2_drain", 64'(data_out), 64'(mk(32'h100 + 32'(4 * i))));
            tick();
        end
        checkOutput("t2_empty", 64'(count), 64'd0);

        // Steady push+pop at occupancy 4 across pointer wrap
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(4 * (i + 4)), 1'b1, 1'b0);
            #1;
            checkOutput("t3_seq", 64'(data_out), 64'(mk(32'h300 + 32'(4 * i))));
            tick();
            checkOutput("t3_count4", 64'(count), 64'd4);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 20; i < 24; i++) begin
            #1;
            checkOutput("t3_drain", 64'(data_out), 64'(mk(32'h300 + 32'(4 * i))));
            tick();
        end
        checkOutput("t3_empty", 64'(count), 64'd0);

        // Mispredict flush at occupancy 5 with a concurrent push
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("t4_count5", 64'(count), 64'd5);
        applyStimulus(1'b1, 32'h5FC, 1'b0, 1'b1);
        #1;
        checkOutput("t4_valid_in_flush", 64'(valid_out), 64'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t4_count0", 64'(count), 64'd0);
        checkOutput("t4_valid0", 64'(valid_out), 64'd0);
        checkOutput("t4_data0", 64'(data_out), 64'd0);
        applyStimulus(1'b1, 32'h600, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t4_post_flush_head", 64'(data_out), 64'(mk(32'h600)));
        checkOutput("t4_post_flush_count", 64'(count), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t4_empty", 64'(count), 64'd0);

        // Asynchronous reset mid-operation at occupancy 6
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'h700 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t5_count6", 64'(count), 64'd6);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("t5_async_valid", 64'(valid_out), 64'd0);
        checkOutput("t5_async_count", 64'(count), 64'd0);
        checkOutput("t5_async_ready", 64'(ready_in), 64'd0);
        checkOutput("t5_async_data", 64'(data_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 32'h800, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t5_first_push_count", 64'(count), 64'd1);
        checkOutput("t5_first_push_data", 64'(data_out), 64'(mk(32'h800)));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t5_empty", 64'(count), 64'd0);

        // Empty queue offered an instruction while rename is ready
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0);
        #1;
`ifdef DECODE_QUEUE_BYPASS_EN
        checkOutput("bypass_valid", 64'(valid_out), 64'd1);
        checkOutput("bypass_pc", 64'(data_out.pc), 64'h40);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("bypass_count0", 64'(count), 64'd0);
`else
        checkOutput("nobypass_valid", 64'(valid_out), 64'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("nobypass_count1", 64'(count), 64'd1);
        checkOutput("nobypass_pc", 64'(data_out.pc), 64'h40);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("nobypass_count0", 64'(count), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
